// File: rtl/rv_exec_wb_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_exec_wb_stage_pkg
// Description : Shared types for the execute/writeback stage: the decode
//               select encodings it consumes (WB_SRC, OP1_SEL, OP2_SEL),
//               the stage FSM states and the bundle of registered ID fields.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_exec_wb_stage_pkg;

  // Writeback source select, as produced by decode
  localparam logic [1:0] WB_SRC_ALU = 2'd0;
  localparam logic [1:0] WB_SRC_MDU = 2'd1;
  localparam logic [1:0] WB_SRC_LSU = 2'd2;
  localparam logic [1:0] WB_SRC_CSR = 2'd3;

  // Operand 1 select; code 2'd2 is unused by decode and reads as zero
  localparam logic [1:0] OP1_SEL_RS1_DATA   = 2'd0;
  localparam logic [1:0] OP1_SEL_CURRENT_PC = 2'd1;
  localparam logic [1:0] OP1_SEL_RSVD       = 2'd2;
  localparam logic [1:0] OP1_SEL_ZERO       = 2'd3;

  // Operand 2 select
  localparam logic [1:0] OP2_SEL_RS2_DATA = 2'd0;
  localparam logic [1:0] OP2_SEL_IMM_I    = 2'd1;
  localparam logic [1:0] OP2_SEL_IMM_U    = 2'd2;
  localparam logic [1:0] OP2_SEL_NEXT_PC  = 2'd3;

  // Stage FSM: IDLE = empty, EXEC = operands valid, WAIT = MDU/LSU outstanding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WAIT = 2'd2
  } exec_state_e;

  // ID fields that must survive past the accept edge (operands are held separately)
  typedef struct packed {
    logic [1:0] wb_src;
    logic [4:0] rd_addr;
    logic       rd_we;
  } exec_instr_t;

  // True when the result comes from a multi-cycle unit with a done handshake
  function automatic logic wb_src_is_async(input logic [1:0] wb_src);
    return (wb_src == WB_SRC_MDU) || (wb_src == WB_SRC_LSU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rv_exec_wb_stage_operand_mux.sv
`default_nettype none
// ============================================================================
// Module      : rv_operand_mux
// Description : Combinational ALU/MDU operand selection from the decode
//               OP1_SEL / OP2_SEL codes. NEXT_PC wraps modulo 2^XLEN.
// Revision    : 1.0 - initial release
// ============================================================================
module rv_operand_mux
  import rv_exec_wb_stage_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int PC_INC = 4
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [XLEN-1:0] imm_i_i,
  input  logic [XLEN-1:0] imm_u_i,
  input  logic [1:0]      op1_sel_i,
  input  logic [1:0]      op2_sel_i,
  output logic [XLEN-1:0] op1_o,
  output logic [XLEN-1:0] op2_o
);

  localparam logic [XLEN-1:0] PC_INC_W = XLEN'(PC_INC);

  // Operand 1: register, PC, or zero (reserved code also yields zero)
  always_comb begin
    op1_o = '0;
    case (op1_sel_i)
      OP1_SEL_RS1_DATA:   op1_o = rs1_data_i;
      OP1_SEL_CURRENT_PC: op1_o = pc_i;
      default:            op1_o = '0;
    endcase
  end

  // Operand 2: register, immediates, or link address (carry out discarded)
  always_comb begin
    op2_o = '0;
    case (op2_sel_i)
      OP2_SEL_RS2_DATA: op2_o = rs2_data_i;
      OP2_SEL_IMM_I:    op2_o = imm_i_i;
      OP2_SEL_IMM_U:    op2_o = imm_u_i;
      default:          op2_o = pc_i + PC_INC_W;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/rv_exec_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : rv_exec_wb_stage
// Description : Execute/writeback stage. Registers one decoded instruction,
//               builds operands, hands MDU/LSU work off with a level request
//               and a done pulse, and emits one registered writeback beat per
//               completed instruction.
//               Optional: define RV_EXEC_PERF_EN to add stall/retire counters.
// Revision    : 1.0 - initial release
// ============================================================================
module rv_exec_wb_stage
  import rv_exec_wb_stage_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int PC_INC = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            kill_i,
  input  logic            id_valid_i,
  output logic            id_ready_o,
  input  logic [XLEN-1:0] id_pc_i,
  input  logic [XLEN-1:0] id_rs1_data_i,
  input  logic [XLEN-1:0] id_rs2_data_i,
  input  logic [XLEN-1:0] id_imm_i_i,
  input  logic [XLEN-1:0] id_imm_u_i,
  input  logic [1:0]      id_op1_sel_i,
  input  logic [1:0]      id_op2_sel_i,
  input  logic [1:0]      id_wb_src_i,
  input  logic [4:0]      id_rd_addr_i,
  input  logic            id_rd_we_i,
  output logic [XLEN-1:0] op1_o,
  output logic [XLEN-1:0] op2_o,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic [XLEN-1:0] csr_rdata_i,
  output logic            mdu_req_o,
  input  logic            mdu_done_i,
  input  logic [XLEN-1:0] mdu_result_i,
  output logic            lsu_req_o,
  input  logic            lsu_done_i,
  input  logic [XLEN-1:0] lsu_rdata_i,
  output logic            wb_valid_o,
  output logic            wb_we_o,
  output logic [4:0]      wb_rd_addr_o,
  output logic [XLEN-1:0] wb_data_o
`ifdef RV_EXEC_PERF_EN
  ,
  output logic [31:0]     perf_stall_cnt_o,
  output logic [31:0]     perf_retire_cnt_o
`endif
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  exec_state_e     state_q, state_d;
  exec_instr_t     instr_q, instr_d;
  logic [XLEN-1:0] op1_q, op1_d;
  logic [XLEN-1:0] op2_q, op2_d;
  logic            wb_valid_q, wb_valid_d;
  logic            wb_we_q, wb_we_d;
  logic [4:0]      wb_rd_addr_q, wb_rd_addr_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] op1_sel;
  logic [XLEN-1:0] op2_sel;
  logic [XLEN-1:0] result;
  logic            is_async;
  logic            is_mdu;
  logic            is_lsu;
  logic            busy;
  logic            sel_done;
  logic            complete;
  logic            ready;
  logic            accept;

  rv_operand_mux #(
    .XLEN   (XLEN),
    .PC_INC (PC_INC)
  ) u_operand_mux (
    .pc_i       (id_pc_i),
    .rs1_data_i (id_rs1_data_i),
    .rs2_data_i (id_rs2_data_i),
    .imm_i_i    (id_imm_i_i),
    .imm_u_i    (id_imm_u_i),
    .op1_sel_i  (id_op1_sel_i),
    .op2_sel_i  (id_op2_sel_i),
    .op1_o      (op1_sel),
    .op2_o      (op2_sel)
  );

  // Completion and handshake decode; done pulses from the other unit or in IDLE are ignored
  always_comb begin
    is_mdu   = (instr_q.wb_src == WB_SRC_MDU);
    is_lsu   = (instr_q.wb_src == WB_SRC_LSU);
    is_async = wb_src_is_async(instr_q.wb_src);
    busy     = (state_q == ST_EXEC) || (state_q == ST_WAIT);
    sel_done = (is_mdu && mdu_done_i) || (is_lsu && lsu_done_i);
    // ALU/CSR finish in their single EXEC cycle; MDU/LSU finish on their own
    // done pulse, which may already arrive in EXEC and then skips WAIT.
    complete = ((state_q == ST_EXEC) && !is_async) || (busy && is_async && sel_done);
    // Held low while reset is asserted so every output reads 0 during reset.
    ready    = !rst_i && ((state_q == ST_IDLE) || complete);
    // A flush wins over a simultaneous accept.
    accept   = id_valid_i && ready && !kill_i;
  end

  // Result select by writeback source
  always_comb begin
    result = alu_result_i;
    case (instr_q.wb_src)
      WB_SRC_ALU: result = alu_result_i;
      WB_SRC_MDU: result = mdu_result_i;
      WB_SRC_LSU: result = lsu_rdata_i;
      default:    result = csr_rdata_i;
    endcase
  end

  // Next-state, capture and writeback-beat generation
  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    op1_d        = op1_q;
    op2_d        = op2_q;
    wb_valid_d   = 1'b0;
    wb_we_d      = 1'b0;
    wb_rd_addr_d = wb_rd_addr_q;
    wb_data_d    = wb_data_q;

    // A flush suppresses the beat that would otherwise register this edge.
    if (complete && !kill_i) begin
      wb_valid_d   = 1'b1;
      wb_we_d      = instr_q.rd_we && (instr_q.rd_addr != 5'd0);
      wb_rd_addr_d = instr_q.rd_addr;
      wb_data_d    = result;
    end

    if (kill_i) begin
      state_d = ST_IDLE;
    end else if (accept) begin
      state_d         = ST_EXEC;
      instr_d.wb_src  = id_wb_src_i;
      instr_d.rd_addr = id_rd_addr_i;
      instr_d.rd_we   = id_rd_we_i;
      op1_d           = op1_sel;
      op2_d           = op2_sel;
    end else if (complete) begin
      state_d = ST_IDLE;
    end else if (state_q == ST_EXEC) begin
      state_d = ST_WAIT;
    end
  end

  // Stage registers with asynchronous reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      instr_q      <= '0;
      op1_q        <= '0;
      op2_q        <= '0;
      wb_valid_q   <= 1'b0;
      wb_we_q      <= 1'b0;
      wb_rd_addr_q <= '0;
      wb_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      instr_q      <= instr_d;
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      wb_valid_q   <= wb_valid_d;
      wb_we_q      <= wb_we_d;
      wb_rd_addr_q <= wb_rd_addr_d;
      wb_data_q    <= wb_data_d;
    end
  end

  // Requests are decoded from registered state, so reset removes them at once
  assign mdu_req_o    = busy && is_mdu;
  assign lsu_req_o    = busy && is_lsu;
  assign id_ready_o   = ready;
  assign op1_o        = op1_q;
  assign op2_o        = op2_q;
  assign wb_valid_o   = wb_valid_q;
  assign wb_we_o      = wb_we_q;
  assign wb_rd_addr_o = wb_rd_addr_q;
  assign wb_data_o    = wb_data_q;

`ifdef RV_EXEC_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_retire_q, perf_retire_d;

  // Free-running wrap-around event counters
  always_comb begin
    perf_stall_d  = perf_stall_q + {31'd0, (state_q == ST_WAIT)};
    perf_retire_d = perf_retire_q + {31'd0, wb_valid_q};
  end

  // Counter registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_stall_q  <= '0;
      perf_retire_q <= '0;
    end else begin
      perf_stall_q  <= perf_stall_d;
      perf_retire_q <= perf_retire_d;
    end
  end

  assign perf_stall_cnt_o  = perf_stall_q;
  assign perf_retire_cnt_o = perf_retire_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rv_exec_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv_exec_wb_stage
// Description : Self-checking bench for rv_exec_wb_stage. Expected writeback
//               beats are queued when an instruction is issued and compared
//               by a monitor when the stage produces them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_exec_wb_stage;
  import rv_exec_wb_stage_pkg::*;

  localparam int XLEN = 32;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic            kill_i = 1'b0;
  logic            id_valid_i = 1'b0;
  logic            id_ready_o;
  logic [XLEN-1:0] id_pc_i = '0;
  logic [XLEN-1:0] id_rs1_data_i = '0;
  logic [XLEN-1:0] id_rs2_data_i = '0;
  logic [XLEN-1:0] id_imm_i_i = '0;
  logic [XLEN-1:0] id_imm_u_i = '0;
  logic [1:0]      id_op1_sel_i = '0;
  logic [1:0]      id_op2_sel_i = '0;
  logic [1:0]      id_wb_src_i = '0;
  logic [4:0]      id_rd_addr_i = '0;
  logic            id_rd_we_i = 1'b0;
  logic [XLEN-1:0] op1_o;
  logic [XLEN-1:0] op2_o;
  logic [XLEN-1:0] alu_result_i;
  logic [XLEN-1:0] csr_rdata_i = 32'h0000_C5C5;
  logic            mdu_req_o;
  logic            mdu_done_i = 1'b0;
  logic [XLEN-1:0] mdu_result_i = '0;
  logic            lsu_req_o;
  logic            lsu_done_i = 1'b0;
  logic [XLEN-1:0] lsu_rdata_i = '0;
  logic            wb_valid_o;
  logic            wb_we_o;
  logic [4:0]      wb_rd_addr_o;
  logic [XLEN-1:0] wb_data_o;
`ifdef RV_EXEC_PERF_EN
  logic [31:0]     perf_stall_cnt_o;
  logic [31:0]     perf_retire_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [4:0]  rd;
    logic        we;
    logic [31:0] data;
  } wb_exp_t;

  wb_exp_t exp_q[$];

  // ALU stub: adds the two operands
  assign alu_result_i = op1_o + op2_o;

  rv_exec_wb_stage #(.XLEN(XLEN), .PC_INC(4)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .kill_i        (kill_i),
    .id_valid_i    (id_valid_i),
    .id_ready_o    (id_ready_o),
    .id_pc_i       (id_pc_i),
    .id_rs1_data_i (id_rs1_data_i),
    .id_rs2_data_i (id_rs2_data_i),
    .id_imm_i_i    (id_imm_i_i),
    .id_imm_u_i    (id_imm_u_i),
    .id_op1_sel_i  (id_op1_sel_i),
    .id_op2_sel_i  (id_op2_sel_i),
    .id_wb_src_i   (id_wb_src_i),
    .id_rd_addr_i  (id_rd_addr_i),
    .id_rd_we_i    (id_rd_we_i),
    .op1_o         (op1_o),
    .op2_o         (op2_o),
    .alu_result_i  (alu_result_i),
    .csr_rdata_i   (csr_rdata_i),
    .mdu_req_o     (mdu_req_o),
    .mdu_done_i    (mdu_done_i),
    .mdu_result_i  (mdu_result_i),
    .lsu_req_o     (lsu_req_o),
    .lsu_done_i    (lsu_done_i),
    .lsu_rdata_i   (lsu_rdata_i),
    .wb_valid_o    (wb_valid_o),
    .wb_we_o       (wb_we_o),
    .wb_rd_addr_o  (wb_rd_addr_o),
    .wb_data_o     (wb_data_o)
`ifdef RV_EXEC_PERF_EN
    ,
    .perf_stall_cnt_o  (perf_stall_cnt_o),
    .perf_retire_cnt_o (perf_retire_cnt_o)
`endif
  );

  initial forever #5 clk_i = ~clk_i;

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: every writeback beat must match the oldest expectation
  always @(negedge clk_i) begin
    if (wb_valid_o === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: got rd=%0d we=%0b data=%h, expected no beat",
                 wb_rd_addr_o, wb_we_o, wb_data_o);
      end else begin
        wb_exp_t e;
        e = exp_q.pop_front();
        if (wb_rd_addr_o !== e.rd || wb_we_o !== e.we || wb_data_o !== e.data) begin
          errors++;
          $display("FAIL wb_beat: got rd=%0d we=%0b data=%h, expected rd=%0d we=%0b data=%h",
                   wb_rd_addr_o, wb_we_o, wb_data_o, e.rd, e.we, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_id(input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [31:0] immi, input logic [31:0] immu,
                          input logic [1:0] s1, input logic [1:0] s2, input logic [1:0] wbs,
                          input logic [4:0] rd, input logic we);
    id_valid_i    = 1'b1;
    id_pc_i       = pc;
    id_rs1_data_i = rs1;
    id_rs2_data_i = rs2;
    id_imm_i_i    = immi;
    id_imm_u_i    = immu;
    id_op1_sel_i  = s1;
    id_op2_sel_i  = s2;
    id_wb_src_i   = wbs;
    id_rd_addr_i  = rd;
    id_rd_we_i    = we;
  endtask

  task automatic clear_id();
    id_valid_i = 1'b0;
  endtask

  // Issue one ALU/CSR instruction, check operands in EXEC and the beat timing
  task automatic run_single(input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                            input logic [31:0] immi, input logic [31:0] immu,
                            input logic [1:0] s1, input logic [1:0] s2, input logic [1:0] wbs,
                            input logic [4:0] rd, input logic we,
                            input logic [31:0] exp_op1, input logic [31:0] exp_op2,
                            input logic exp_we, input logic [31:0] exp_data, input string name);
    drive_id(pc, rs1, rs2, immi, immu, s1, s2, wbs, rd, we);
    exp_q.push_back('{rd: rd, we: exp_we, data: exp_data});
    tick();
    clear_id();
    checks++;
    if (op1_o !== exp_op1) begin
      errors++;
      $display("FAIL %s op1: got %h expected %h", name, op1_o, exp_op1);
    end
    checks++;
    if (op2_o !== exp_op2) begin
      errors++;
      $display("FAIL %s op2: got %h expected %h", name, op2_o, exp_op2);
    end
    tick();
    checks++;
    if (wb_valid_o !== 1'b1 || wb_we_o !== exp_we) begin
      errors++;
      $display("FAIL %s wb_timing: got valid=%0b we=%0b expected valid=1 we=%0b",
               name, wb_valid_o, wb_we_o, exp_we);
    end
    tick();
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({id_ready_o, mdu_req_o, lsu_req_o, wb_valid_o, wb_we_o} !== 5'b0 ||
        op1_o !== '0 || op2_o !== '0 || wb_data_o !== '0 || wb_rd_addr_o !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%0b mreq=%0b lreq=%0b wbv=%0b op1=%h op2=%h wbd=%h, expected all 0",
               id_ready_o, mdu_req_o, lsu_req_o, wb_valid_o, op1_o, op2_o, wb_data_o);
    end
    tick();
    tick();
    rst_i = 1'b0;
    #1;
    checks++;
    if (id_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %0b expected 1", id_ready_o);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    drive_id(0, 32'd5, 0, 32'd7, 0, OP1_SEL_RS1_DATA, OP2_SEL_IMM_I, WB_SRC_ALU, 5'd3, 1'b1);
    exp_q.push_back('{rd: 5'd3, we: 1'b1, data: 32'd12});
    tick();
    drive_id(0, 32'd10, 0, 32'd20, 0, OP1_SEL_RS1_DATA, OP2_SEL_IMM_I, WB_SRC_ALU, 5'd4, 1'b1);
    exp_q.push_back('{rd: 5'd4, we: 1'b1, data: 32'd30});
    checks++;
    if (id_ready_o !== 1'b1 || op1_o !== 32'd5 || op2_o !== 32'd7) begin
      errors++;
      $display("FAIL b2b_exec: got ready=%0b op1=%h op2=%h expected ready=1 op1=5 op2=7",
               id_ready_o, op1_o, op2_o);
    end
    tick();
    clear_id();
    checks++;
    if (wb_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first_beat: got valid=%0b expected 1", wb_valid_o);
    end
    tick();
    checks++;
    if (wb_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_beat: got valid=%0b expected 1", wb_valid_o);
    end
    tick();
    checks++;
    if (wb_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_pulse_end: got valid=%0b expected 0", wb_valid_o);
    end
  endtask

  task automatic test_operand_select();
    // JAL-style link: pc + 4 wraps to zero
    run_single(32'hFFFF_FFFC, 0, 0, 0, 0, OP1_SEL_CURRENT_PC, OP2_SEL_NEXT_PC, WB_SRC_ALU,
               5'd1, 1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 1'b1, 32'hFFFF_FFFC, "jal_wrap");
    run_single(32'h100, 32'hAAAA, 0, 0, 32'h1234_5000, OP1_SEL_ZERO, OP2_SEL_IMM_U, WB_SRC_ALU,
               5'd2, 1'b1, 32'h0, 32'h1234_5000, 1'b1, 32'h1234_5000, "lui_zero");
    run_single(32'h100, 32'hAAAA, 32'h77, 0, 0, OP1_SEL_RSVD, OP2_SEL_RS2_DATA, WB_SRC_ALU,
               5'd9, 1'b1, 32'h0, 32'h77, 1'b1, 32'h77, "op1_rsvd");
    run_single(32'h200, 32'h3, 32'h4, 0, 0, OP1_SEL_RS1_DATA, OP2_SEL_RS2_DATA, WB_SRC_CSR,
               5'd11, 1'b1, 32'h3, 32'h4, 1'b1, 32'h0000_C5C5, "csr_read");
    run_single(32'h0, 32'h5, 32'h6, 0, 0, OP1_SEL_RS1_DATA, OP2_SEL_RS2_DATA, WB_SRC_ALU,
               5'd0, 1'b1, 32'h5, 32'h6, 1'b0, 32'hB, "rd_x0");
    run_single(32'h0, 32'h1, 32'h1, 0, 0, OP1_SEL_RS1_DATA, OP2_SEL_RS2_DATA, WB_SRC_ALU,
               5'd12, 1'b0, 32'h1, 32'h1, 1'b0, 32'h2, "rd_we0");
  endtask

  task automatic test_mdu_wait();
    int req_cycles = 0;
    drive_id(0, 32'd6, 32'd7, 0, 0, OP1_SEL_RS1_DATA, OP2_SEL_RS2_DATA, WB_SRC_MDU, 5'd5, 1'b1);
    tick();
    clear_id();
    // Request cycle 1 (EXEC) and 2 (WAIT): stage must stall
    for (int i = 0; i < 2; i++) begin
      if (mdu_req_o === 1'b1) req_cycles++;
      if (i == 1) lsu_done_i = 1'b1;   // stray done from the other unit
      #1;
      checks++;
      if (id_ready_o !== 1'b0 || lsu_req_o !== 1'b0) begin
        errors++;
        $display("FAIL mdu_stall: cycle %0d got ready=%0b lreq=%0b expected 0 0", i, id_ready_o, lsu_req_o);
      end
      tick();
      lsu_done_i = 1'b0;
    end
    if (mdu_req_o === 1'b1) req_cycles++;
    mdu_done_i   = 1'b1;
    mdu_result_i = 32'h0000_DEAD;
    exp_q.push_back('{rd: 5'd5, we: 1'b1, data: 32'h0000_DEAD});
    #1;
    checks++;
    if (id_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL mdu_done_ready: got %0b expected 1", id_ready_o);
    end
    tick();
    mdu_done_i = 1'b0;
    checks++;
    if (req_cycles != 3 || mdu_req_o !== 1'b0 || wb_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL mdu_complete: got req_cycles=%0d req=%0b wbv=%0b expected 3 0 1",
               req_cycles, mdu_req_o, wb_valid_o);
    end
    tick();
  endtask

  task automatic test_lsu_same_cycle();
    drive_id(0, 32'h40, 0, 32'h4, 0, OP1_SEL_RS1_DATA, OP2_SEL_IMM_I, WB_SRC_LSU, 5'd6, 1'b1);
    tick();
    clear_id();
    lsu_done_i  = 1'b1;
    lsu_rdata_i = 32'h55;
    exp_q.push_back('{rd: 5'd6, we: 1'b1, data: 32'h55});
    checks++;
    if (lsu_req_o !== 1'b1) begin
      errors++;
      $display("FAIL lsu_req_rise: got %0b expected 1", lsu_req_o);
    end
    tick();
    lsu_done_i = 1'b0;
    checks++;
    if (wb_valid_o !== 1'b1 || lsu_req_o !== 1'b0 || id_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL lsu_no_wait: got wbv=%0b req=%0b ready=%0b expected 1 0 1",
               wb_valid_o, lsu_req_o, id_ready_o);
    end
    // Stray MDU done while idle
    mdu_done_i = 1'b1;
    tick();
    mdu_done_i = 1'b0;
    tick();
    checks++;
    if (wb_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL stray_done_idle: got wbv=%0b expected 0", wb_valid_o);
    end
  endtask

  task automatic test_kill();
    // Kill during WAIT, then a late done must not produce a beat
    drive_id(0, 0, 0, 0, 0, OP1_SEL_RS1_DATA, OP2_SEL_RS2_DATA, WB_SRC_LSU, 5'd7, 1'b1);
    tick();
    clear_id();
    tick();
    kill_i = 1'b1;
    tick();
    kill_i = 1'b0;
    checks++;
    if (lsu_req_o !== 1'b0 || id_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL kill_wait: got req=%0b ready=%0b expected 0 1", lsu_req_o, id_ready_o);
    end
    lsu_done_i = 1'b1;
    tick();
    lsu_done_i = 1'b0;
    checks++;
    if (wb_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL kill_late_done: got wbv=%0b expected 0", wb_valid_o);
    end
    run_single(0, 32'd1, 0, 32'd2, 0, OP1_SEL_RS1_DATA, OP2_SEL_IMM_I, WB_SRC_ALU,
               5'd8, 1'b1, 32'd1, 32'd2, 1'b1, 32'd3, "post_kill");
    // Kill in EXEC beats a simultaneous accept and suppresses the pending beat
    drive_id(0, 32'h21, 0, 32'h1, 0, OP1_SEL_RS1_DATA, OP2_SEL_IMM_I, WB_SRC_ALU, 5'd9, 1'b1);
    tick();
    drive_id(0, 32'h100, 0, 32'h1, 0, OP1_SEL_RS1_DATA, OP2_SEL_IMM_I, WB_SRC_ALU, 5'd10, 1'b1);
    kill_i = 1'b1;
    tick();
    kill_i = 1'b0;
    clear_id();
    checks++;
    if (wb_valid_o !== 1'b0 || op1_o !== 32'h21) begin
      errors++;
      $display("FAIL kill_priority: got wbv=%0b op1=%h expected 0 00000021", wb_valid_o, op1_o);
    end
    tick();
    checks++;
    if (wb_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL kill_dropped_accept: got wbv=%0b expected 0", wb_valid_o);
    end
    // A beat already visible is not retracted by a kill
    drive_id(0, 32'h30, 0, 32'h3, 0, OP1_SEL_RS1_DATA, OP2_SEL_IMM_I, WB_SRC_ALU, 5'd13, 1'b1);
    exp_q.push_back('{rd: 5'd13, we: 1'b1, data: 32'h33});
    tick();
    clear_id();
    tick();
    kill_i = 1'b1;
    #1;
    checks++;
    if (wb_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL kill_visible_beat: got wbv=%0b expected 1", wb_valid_o);
    end
    tick();
    kill_i = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    drive_id(0, 0, 0, 0, 0, OP1_SEL_RS1_DATA, OP2_SEL_RS2_DATA, WB_SRC_MDU, 5'd14, 1'b1);
    tick();
    clear_id();
    tick();
    checks++;
    if (mdu_req_o !== 1'b1) begin
      errors++;
      $display("FAIL wait_req_before_reset: got %0b expected 1", mdu_req_o);
    end
    #1;
    rst_i = 1'b1;
    #1;
    checks++;
    if ({id_ready_o, mdu_req_o, lsu_req_o, wb_valid_o, wb_we_o} !== 5'b0 ||
        op1_o !== '0 || op2_o !== '0 || wb_data_o !== '0 || wb_rd_addr_o !== '0) begin
      errors++;
      $display("FAIL async_reset: got ready=%0b mreq=%0b wbv=%0b op1=%h wbd=%h expected all 0",
               id_ready_o, mdu_req_o, wb_valid_o, op1_o, wb_data_o);
    end
    tick();
    rst_i = 1'b0;
    #1;
    checks++;
    if (id_ready_o !== 1'b1 || mdu_req_o !== 1'b0) begin
      errors++;
      $display("FAIL after_reset: got ready=%0b mreq=%0b expected 1 0", id_ready_o, mdu_req_o);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_operand_select();
    test_mdu_wait();
    test_lsu_same_cycle();
    test_kill();
    test_reset_in_wait();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d beats outstanding expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
